// File: rtl/alu_cmd_pkg.sv
// alu_cmd_pkg: ALU function codes, opcode legality check and sequencer state type.
package alu_cmd_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SHL = 3'b111;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SHL};
    endfunction

endpackage

// File: rtl/alu_cmd_seq_if.sv
// alu_cmd_seq_if: command, response and external-ALU signals of the sequencer.
interface alu_cmd_seq_if #(
    parameter int REG_AW = 2
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [REG_AW-1:0] cmd_rd;
    logic [REG_AW-1:0] cmd_ra;
    logic [REG_AW-1:0] cmd_rb;
    logic              cmd_imm_en;
    logic [31:0]       cmd_imm;
    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [2:0]        alu_f;
    logic [31:0]       alu_y;
    logic              alu_zero;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_zero;
    logic              rsp_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
        input  alu_y, alu_zero, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_f, rsp_valid, rsp_data, rsp_zero, rsp_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
        output alu_y, alu_zero, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_f, rsp_valid, rsp_data, rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu_cmd_regfile.sv
// alu_cmd_regfile: 32-bit operand registers, two async read ports, one sync write port.
module alu_cmd_regfile #(
    parameter int NUM_REGS = 4,
    parameter int REG_AW   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [31:0]       wd_i,
    input  logic [REG_AW-1:0] ra_i,
    input  logic [REG_AW-1:0] rb_i,
    output logic [31:0]       rda_o,
    output logic [31:0]       rdb_o
);

    logic [31:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rda_o = regs_q[ra_i];
    assign rdb_o = regs_q[rb_i];

endmodule

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: sequences register-file commands through an external ALU, IDLE->ISSUE->RESP.
// Defining ALU_CMD_SEQ_STATS_EN adds saturating legal/illegal command counters.
module alu_cmd_seq
    import alu_cmd_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int REG_AW   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_cmd_seq_if.slave bus
`ifdef ALU_CMD_SEQ_STATS_EN
    ,
    output logic [15:0]  stat_cmds,
    output logic [15:0]  stat_errs
`endif
);

    state_e            state_q;
    logic              cmd_ready_q, rsp_valid_q, rsp_zero_q, rsp_err_q, imm_en_q;
    logic [31:0]       rsp_data_q, imm_q, rda, rdb;
    logic [2:0]        op_q;
    logic [REG_AW-1:0] rd_q, ra_q, rb_q;
    logic              issue;

    assign issue = (state_q == ISSUE);

    alu_cmd_regfile #(.NUM_REGS(NUM_REGS), .REG_AW(REG_AW)) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (issue),
        .wa_i  (rd_q),
        .wd_i  (bus.alu_y),
        .ra_i  (ra_q),
        .rb_i  (rb_q),
        .rda_o (rda),
        .rdb_o (rdb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            op_q        <= '0;
            rd_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            imm_en_q    <= 1'b0;
            imm_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.cmd_valid) begin
                    op_q        <= bus.cmd_op;
                    rd_q        <= bus.cmd_rd;
                    ra_q        <= bus.cmd_ra;
                    rb_q        <= bus.cmd_rb;
                    imm_en_q    <= bus.cmd_imm_en;
                    imm_q       <= bus.cmd_imm;
                    cmd_ready_q <= 1'b0;
                    // Illegal opcodes skip the ALU and answer immediately
                    if (is_legal_op(bus.cmd_op)) begin
                        state_q <= ISSUE;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_zero_q  <= 1'b0;
                        rsp_err_q   <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= bus.alu_y;
                    rsp_zero_q  <= bus.alu_zero;
                    rsp_err_q   <= 1'b0;
                end
                RESP: if (bus.rsp_ready) begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.alu_a     = issue ? rda : '0;
    assign bus.alu_b     = issue ? (imm_en_q ? imm_q : rdb) : '0;
    assign bus.alu_f     = issue ? op_q : 3'b000;

`ifdef ALU_CMD_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cmds <= '0;
            stat_errs <= '0;
        end else if (state_q == RESP && bus.rsp_ready) begin
            if (rsp_err_q) stat_errs <= stat_errs + {15'd0, ~&stat_errs};
            else           stat_cmds <= stat_cmds + {15'd0, ~&stat_cmds};
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb_alu_cmd_seq: directed table, corner sequences and random commands against a register/ALU model.
module tb_alu_cmd_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_seq_if #(.REG_AW(2)) bus ();

`ifdef ALU_CMD_SEQ_STATS_EN
    logic [15:0] stat_cmds, stat_errs;
    int exp_cmds = 0, exp_errs = 0;
`endif

    alu_cmd_seq #(.NUM_REGS(4), .REG_AW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ALU_CMD_SEQ_STATS_EN
        ,
        .stat_cmds (stat_cmds),
        .stat_errs (stat_errs)
`endif
    );

    int checks = 0, errors = 0;
    logic [31:0] regs [4];

    function automatic logic [31:0] alu_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return a << b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // External combinational ALU
    assign bus.alu_y    = alu_ref(bus.alu_f, bus.alu_a, bus.alu_b);
    assign bus.alu_zero = (bus.alu_y == 32'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) regs[i] = 32'd0;
`ifdef ALU_CMD_SEQ_STATS_EN
        exp_cmds = 0;
        exp_errs = 0;
`endif
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the response handshake.
    task automatic run_cmd(input logic [2:0] op, input int rd, input int ra, input int rb, input bit ie,
                           input logic [31:0] imm, input int hold, input bit keep,
                           output logic [31:0] d, output logic z, output logic e);
        logic [31:0] ea, eb, ey;
        bit legal;
        legal = op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
        ea = regs[ra];
        eb = ie ? imm : regs[rb];
        ey = legal ? alu_ref(op, ea, eb) : 32'd0;
        bus.cmd_op = op;
        bus.cmd_rd = rd[1:0];
        bus.cmd_ra = ra[1:0];
        bus.cmd_rb = rb[1:0];
        bus.cmd_imm_en = ie;
        bus.cmd_imm = imm;
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = (hold == 0);
        chk("idle_ready", bus.cmd_ready, 1);
        @(posedge clk); #1;
        if (!keep) bus.cmd_valid = 1'b0;
        if (legal) begin
            chk("issue_valid", bus.rsp_valid, 0);
            chk("issue_ready", bus.cmd_ready, 0);
            chk("issue_a", bus.alu_a, ea);
            chk("issue_b", bus.alu_b, eb);
            chk("issue_f", bus.alu_f, {29'd0, op});
            @(posedge clk); #1;
            regs[rd] = ey;
        end else begin
            chk("idle_alu_f", bus.alu_f, 0);
        end
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_data", bus.rsp_data, ey);
        chk("rsp_zero", bus.rsp_zero, {31'd0, legal && ey == 32'd0});
        chk("rsp_err", bus.rsp_err, {31'd0, !legal});
        chk("rsp_cmd_ready", bus.cmd_ready, 0);
        d = bus.rsp_data;
        z = bus.rsp_zero;
        e = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_data", bus.rsp_data, ey);
            chk("hold_ready", bus.cmd_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_valid", bus.rsp_valid, 0);
        chk("done_ready", bus.cmd_ready, 1);
`ifdef ALU_CMD_SEQ_STATS_EN
        if (legal) exp_cmds++;
        else exp_errs++;
`endif
    endtask

    typedef struct {
        logic [2:0]  op;
        int          rd, ra, rb;
        bit          ie;
        logic [31:0] imm;
        logic [31:0] ed;
        logic        ez, ee;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [31:0] d;
        logic z, e;
        tbl[0] = '{3'b010, 0, 0, 0, 1, 32'd5,  32'd5,          1'b0, 1'b0};
        tbl[1] = '{3'b010, 1, 0, 0, 1, 32'd7,  32'd12,         1'b0, 1'b0};
        tbl[2] = '{3'b110, 2, 1, 0, 1, 32'd12, 32'd0,          1'b1, 1'b0};
        tbl[3] = '{3'b111, 3, 0, 0, 1, 32'd3,  32'd40,         1'b0, 1'b0};
        tbl[4] = '{3'b011, 0, 1, 2, 0, 32'd9,  32'd0,          1'b0, 1'b1};
        tbl[5] = '{3'b001, 0, 0, 1, 0, 32'd0,  32'd13,         1'b0, 1'b0};
        tbl[6] = '{3'b000, 1, 1, 3, 0, 32'd0,  32'd8,          1'b0, 1'b0};
        tbl[7] = '{3'b010, 1, 1, 1, 0, 32'd0,  32'd16,         1'b0, 1'b0};
        tbl[8] = '{3'b100, 2, 0, 1, 1, 32'd4,  32'd0,          1'b0, 1'b1};
        tbl[9] = '{3'b110, 2, 0, 1, 0, 32'd0,  32'hFFFF_FFFD,  1'b0, 1'b0};

        bus.cmd_valid = 1'b0;
        bus.cmd_op = 3'b000;
        bus.cmd_rd = 2'd0;
        bus.cmd_ra = 2'd0;
        bus.cmd_rb = 2'd0;
        bus.cmd_imm_en = 1'b0;
        bus.cmd_imm = 32'd0;
        bus.rsp_ready = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_valid", bus.rsp_valid, 0);
        chk("rst_data", bus.rsp_data, 0);
        chk("rst_zero", bus.rsp_zero, 0);
        chk("rst_err", bus.rsp_err, 0);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_alu_f", bus.alu_f, 0);

        for (int i = 0; i < 10; i++) begin
            run_cmd(tbl[i].op, tbl[i].rd, tbl[i].ra, tbl[i].rb, tbl[i].ie, tbl[i].imm, i % 3, 1'b0, d, z, e);
            chk($sformatf("tbl%0d_data", i), d, tbl[i].ed);
            chk($sformatf("tbl%0d_zero", i), {31'd0, z}, {31'd0, tbl[i].ez});
            chk($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].ee});
        end

        // Long stall with the next command already offered; it must wait for the handshake
        run_cmd(3'b010, 3, 1, 0, 1'b1, 32'd100, 5, 1'b1, d, z, e);
        chk("stall_data", d, 32'd116);
        run_cmd(3'b010, 3, 1, 0, 1'b1, 32'd100, 0, 1'b0, d, z, e);
        chk("pend_data", d, 32'd116);

        // Reset while ISSUE is in progress
        bus.cmd_op = 3'b010;
        bus.cmd_rd = 2'd3;
        bus.cmd_ra = 2'd0;
        bus.cmd_imm_en = 1'b1;
        bus.cmd_imm = 32'd1;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        chk("abort_in_issue", bus.alu_f, 3'b010);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", bus.rsp_valid, 0);
        chk("abort_ready", bus.cmd_ready, 1);
        chk("abort_data", bus.rsp_data, 0);
        chk("abort_alu_a", bus.alu_a, 0);
        chk("abort_alu_f", bus.alu_f, 0);
        clear_model();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("abort_no_rsp", bus.rsp_valid, 0);
        end
        run_cmd(3'b001, 0, 3, 0, 1'b1, 32'd0, 0, 1'b0, d, z, e);
        chk("abort_reg3", d, 32'd0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] imm;
            imm = (n % 4 == 0) ? 32'd0 : $urandom;
            run_cmd(3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), imm, $urandom_range(0, 2), 1'b0, d, z, e);
        end

`ifdef ALU_CMD_SEQ_STATS_EN
        chk("stat_cmds", {16'd0, stat_cmds}, exp_cmds);
        chk("stat_errs", {16'd0, stat_errs}, exp_errs);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of 32-bit internal operand registers.
REQ-002 SHALL have parameter REG_AW, default 2, register index width (= clog2(NUM_REGS)).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready on a clk edge.
REQ-007 cmd_op  input  3  ALU function code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SHL; others illegal.
REQ-008 cmd_rd, cmd_ra, cmd_rb  input  REG_AW each  destination, operand-A, operand-B register index.
REQ-009 cmd_imm_en  input  1  1 = operand B taken from cmd_imm instead of register rb.
REQ-010 cmd_imm  input  32  immediate operand B.
REQ-011 alu_a, alu_b  output  32 each  operands driven to the external combinational ALU.
REQ-012 alu_f  output  3  function code driven to the ALU.
REQ-013 alu_y  input  32  ALU result; alu_zero  input  1  ALU result-is-zero flag.
REQ-014 rsp_valid  output  1  response present; rsp_ready  input  1  response consumed.
REQ-015 rsp_data  output  32  result; rsp_zero  output  1  zero flag; rsp_err  output  1  illegal opcode.

Function
REQ-016 SHALL implement FSM with states IDLE, ISSUE, RESP.
REQ-017 IDLE: cmd_ready=1; on handshake latch op, rd, ra, rb, imm_en, imm; legal op -> ISSUE, illegal op -> RESP with rsp_err=1, rsp_data=0, rsp_zero=0, no register write.
REQ-018 ISSUE (exactly one cycle): alu_a=reg[ra], alu_b=imm_en ? imm : reg[rb], alu_f=op, all from latched values; at the closing edge capture alu_y into reg[rd] and rsp_data, alu_zero into rsp_zero, rsp_err=0; -> RESP.
REQ-019 RESP: rsp_valid=1, rsp_data/rsp_zero/rsp_err held stable until rsp_valid & rsp_ready; then -> IDLE.
REQ-020 cmd_ready SHALL be 0 in ISSUE and RESP; rsp_valid SHALL be 0 in IDLE and ISSUE.
REQ-021 Latency: legal command accepted at edge N -> rsp_valid high in the cycle after edge N+1; illegal command -> rsp_valid after edge N.
REQ-022 Outside ISSUE, alu_a=0, alu_b=0, alu_f=3'b000.
REQ-023 rd equal to ra or rb SHALL be allowed; operands are read before the write (write lands at ISSUE closing edge).
REQ-024 Result written next command is visible to that command's reads (no stale data; min throughput 1 command / 3 cycles).
REQ-025 rsp_ready held high SHALL still give exactly one response per command.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, all registers 0, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0, latched command 0, cmd_ready=1 (after release).
REQ-027 Reset during ISSUE or RESP SHALL abort the command: no register write, no response.

Configuration
REQ-028 Macro ALU_CMD_SEQ_STATS_EN: when defined, add outputs stat_cmds[15:0] (legal commands completed) and stat_errs[15:0] (illegal commands), each incremented on its RESP handshake, saturating at 16'hFFFF, reset to 0.
REQ-029 Without ALU_CMD_SEQ_STATS_EN the ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-030 Package alu_cmd_pkg SHALL hold the function-code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SHL), an is_legal_op function, and the FSM state enum.
REQ-031 Register file SHALL be sub-module alu_cmd_regfile (2 async read ports, 1 sync write port, async active-low clear).

Verification (bench pairs with a behavioural ALU model)
REQ-032 reg0=5 via ADD imm (ra=0, imm 5, rd=0), then ADD ra=0 imm=7 rd=1 -> rsp_data=12, rsp_zero=0, reg1=12, response in 2nd cycle after accept.
REQ-033 reg1=12, SUB ra=1 imm=12 rd=2 -> rsp_data=0, rsp_zero=1; SHL ra=0(=5) imm=3 -> rsp_data=40.
REQ-034 cmd_op=3'b011 -> rsp_err=1, rsp_data=0, response after 1 cycle, all registers unchanged.
REQ-035 rsp_ready low 5 cycles -> rsp_valid and data stable, cmd_ready=0 throughout; 2nd cmd_valid held is accepted only after RESP handshake.
REQ-036 rst_n low during ISSUE of ADD rd=3 -> reg3 stays 0, no rsp_valid, outputs at reset values; with ALU_CMD_SEQ_STATS_EN, 3 legal + 1 illegal commands -> stat_cmds=3, stat_errs=1.
